// File: rtl/mac_accumulator_if.sv
// Handshake and result bundle for mac_accumulator: operand stream in, accumulated sum and status out.
interface mac_accumulator_if;
  logic        start;
  logic [31:0] x;
  logic [31:0] y;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] acc_out;
  logic        out_valid;
  logic        ovf;
  logic        busy;

  modport master (
    output start, x, y, in_valid,
    input  in_ready, acc_out, out_valid, ovf, busy
  );

  modport slave (
    input  start, x, y, in_valid,
    output in_ready, acc_out, out_valid, ovf, busy
  );
endinterface

// File: rtl/mac_accumulator.sv
// mac_accumulator: accumulates the high product words of a burst of TERMS operand pairs.
// Optional macro MAC_SATURATE_EN clamps the sum at 0xFFFFFFFF on overflow instead of wrapping.

module multiplier #(
  parameter int N = 32
) (
  input  logic [N-1:0]   a_i,
  input  logic [N-1:0]   b_i,
  output logic [2*N-1:0] p_o
);
  assign p_o = a_i * b_i;
endmodule

module mac_accumulator #(
  parameter int TERMS = 8
) (
  input  logic           clk,
  input  logic           rst,
  mac_accumulator_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;

  localparam logic [7:0] TERMS_C = 8'(TERMS);

  state_t      state_q, state_d;
  logic [31:0] x_q, x_d, y_q, y_d, prod_q, prod_d, acc_q, acc_d;
  logic        v1_q, v1_d, v2_q, v2_d, ovf_q, ovf_d;
  logic [7:0]  n_acc_q, n_acc_d, n_add_q, n_add_d;
  logic [63:0] mult_p;
  logic [32:0] sum;
  logic        rdy, accept, last_add, unused_lo;

  multiplier #(.N(32)) u_mult (
    .a_i (x_q),
    .b_i (y_q),
    .p_o (mult_p)
  );

  assign unused_lo = ^mult_p[31:0];
  assign sum       = {1'b0, acc_q} + {1'b0, prod_q};
  assign accept    = rdy && bus.in_valid;
  assign last_add  = v2_q && (n_add_q == TERMS_C - 8'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_ACC;
      S_ACC:   if (last_add)  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rdy = (state_q == S_ACC) && (n_acc_q < TERMS_C);
  end

  assign bus.in_ready  = rdy;
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.acc_out   = acc_q;
  assign bus.ovf       = ovf_q;

  // Three-stage pipe: operand capture, product high word, accumulate.
  always_comb begin
    x_d     = accept ? bus.x : x_q;
    y_d     = accept ? bus.y : y_q;
    v1_d    = accept;
    v2_d    = v1_q;
    prod_d  = mult_p[63:32];
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    n_acc_d = n_acc_q;
    n_add_d = n_add_q;
    if (state_q == S_IDLE && bus.start) begin
      acc_d   = '0;
      ovf_d   = 1'b0;
      n_acc_d = '0;
      n_add_d = '0;
    end
    if (accept) n_acc_d = n_acc_q + 8'd1;
    if (v2_q && state_q == S_ACC) begin
      n_add_d = n_add_q + 8'd1;
      ovf_d   = ovf_q | sum[32];
`ifdef MAC_SATURATE_EN
      acc_d   = sum[32] ? 32'hFFFF_FFFF : sum[31:0];
`else
      acc_d   = sum[31:0];
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q     <= '0;
      y_q     <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      prod_q  <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      n_acc_q <= '0;
      n_add_q <= '0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      prod_q  <= prod_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      n_acc_q <= n_acc_d;
      n_add_q <= n_add_d;
    end
  end
endmodule

// File: tb/tb_mac_accumulator.sv
// Bench for mac_accumulator: four instances (TERMS = 2, 3, 4, 8) driven by a vector table and random bursts.
module tb_mac_accumulator;
  localparam int TL [4] = '{2, 3, 4, 8};
`ifdef MAC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  start_s = '0;
  logic [3:0]  vld_s = '0;
  logic [31:0] x_s = '0;
  logic [31:0] y_s = '0;
  logic [3:0]  rdy_w, outv_w, ovf_w, busy_w;
  logic [31:0] acc_w [4];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : gen_dut
    mac_accumulator_if ifc ();
    assign ifc.start    = start_s[g];
    assign ifc.in_valid = vld_s[g];
    assign ifc.x        = x_s;
    assign ifc.y        = y_s;
    assign rdy_w[g]     = ifc.in_ready;
    assign outv_w[g]    = ifc.out_valid;
    assign ovf_w[g]     = ifc.ovf;
    assign busy_w[g]    = ifc.busy;
    assign acc_w[g]     = ifc.acc_out;
    mac_accumulator #(.TERMS(TL[g])) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
    );
  end

  typedef struct {
    int          sel;
    int          mode;
    bit          fix;
    logic [31:0] fx;
    logic [31:0] fy;
    bit          noise;
    bit          xzero;
    bit          has_exp;
    logic [31:0] eacc;
    bit          eovf;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Model: the final sum depends only on the total of accepted high words.
  task automatic run_burst(input int sel, input int mode, input bit fix,
                           input logic [31:0] fx, input logic [31:0] fy,
                           input bit noise, input bit xzero,
                           output logic [31:0] d_acc, output bit d_ovf);
    int t = TL[sel];
    int cnt = 0;
    int e = 0;
    int k = -10;
    bit done = 0;
    bit v;
    bit exp_rdy;
    longint unsigned total = 0;
    logic [31:0] xa, ya, m_acc;
    bit m_ovf;
    start_s[sel] = 1'b1;
    cyc();
    start_s[sel] = 1'b0;
    chk("busy_rise", {31'b0, busy_w[sel]}, 32'd1);
    chk("acc_clear", acc_w[sel], 32'd0);
    chk("ovf_clear", {31'b0, ovf_w[sel]}, 32'd0);
    while (!done) begin
      e++;
      if (e > 4 * t + 20) begin
        n_chk++;
        n_fail++;
        $display("FAIL burst_timeout: got no out_valid after %0d cycles, required within %0d", e, 4 * t + 20);
        break;
      end
      case (mode)
        0:       v = 1'b1;
        1:       v = (e % 2) == 1;
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      xa = fix ? fx : $urandom;
      ya = fix ? fy : $urandom;
      if (xzero) xa = 32'd0;
      x_s = xa;
      y_s = ya;
      vld_s[sel] = v;
      if (noise) start_s[sel] = 1'($urandom_range(0, 1));
      exp_rdy = (cnt < t);
      chk("in_ready", {31'b0, rdy_w[sel]}, {31'b0, exp_rdy});
      cyc();
      if (v && exp_rdy) begin
        cnt++;
        total += ((64'(xa) * 64'(ya)) >> 32);
        if (cnt == t) k = e;
      end
      chk("out_valid", {31'b0, outv_w[sel]}, {31'b0, (e == k + 2)});
      chk("busy", {31'b0, busy_w[sel]}, {31'b0, (k < 0) || (e <= k + 2)});
      if (e == k + 2) begin
        m_ovf = (total >= 64'h1_0000_0000);
        if (!m_ovf)   m_acc = total[31:0];
        else if (SAT) m_acc = 32'hFFFF_FFFF;
        else          m_acc = total[31:0];
        chk("acc_final", acc_w[sel], m_acc);
        chk("ovf_final", {31'b0, ovf_w[sel]}, {31'b0, m_ovf});
      end
      if (e == k + 3) done = 1;
    end
    vld_s[sel] = 1'b0;
    start_s[sel] = 1'b0;
    d_acc = acc_w[sel];
    d_ovf = ovf_w[sel];
    repeat (2) begin
      cyc();
      chk("acc_hold", acc_w[sel], d_acc);
      chk("idle_out_valid", {31'b0, outv_w[sel]}, 32'd0);
    end
  endtask

  initial begin
    vec_t tbl [6];
    logic [31:0] r_acc;
    bit r_ovf;

    tbl[0] = '{0, 0, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 1'b0};
    tbl[1] = '{2, 0, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b1,
               (SAT ? 32'hFFFF_FFFF : 32'h0000_0000), 1'b1};
    tbl[2] = '{3, 1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1'b0, 1'b1, 32'd8, 1'b0};
    tbl[3] = '{1, 0, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0};
    tbl[4] = '{3, 2, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 32'd0, 1'b0};
    tbl[5] = '{1, 2, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0};

    #12;
    for (int s = 0; s < 4; s++) begin
      chk("rst_acc", acc_w[s], 32'd0);
      chk("rst_out_valid", {31'b0, outv_w[s]}, 32'd0);
      chk("rst_ovf", {31'b0, ovf_w[s]}, 32'd0);
      chk("rst_busy", {31'b0, busy_w[s]}, 32'd0);
      chk("rst_in_ready", {31'b0, rdy_w[s]}, 32'd0);
    end
    cyc();
    rst = 1'b0;
    cyc();

    for (int i = 0; i < 6; i++) begin
      run_burst(tbl[i].sel, tbl[i].mode, tbl[i].fix, tbl[i].fx, tbl[i].fy,
                tbl[i].noise, tbl[i].xzero, r_acc, r_ovf);
      if (tbl[i].has_exp) begin
        chk($sformatf("vec%0d_acc", i), r_acc, tbl[i].eacc);
        chk($sformatf("vec%0d_ovf", i), {31'b0, r_ovf}, {31'b0, tbl[i].eovf});
      end
    end

    // Reset mid-burst after two acceptances and one completed add.
    start_s[2] = 1'b1;
    cyc();
    start_s[2] = 1'b0;
    x_s = 32'h8000_0000;
    y_s = 32'h8000_0000;
    vld_s[2] = 1'b1;
    cyc();
    cyc();
    vld_s[2] = 1'b0;
    cyc();
    chk("mid_acc", acc_w[2], 32'h4000_0000);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_acc", acc_w[2], 32'd0);
    chk("async_rst_busy", {31'b0, busy_w[2]}, 32'd0);
    chk("async_rst_in_ready", {31'b0, rdy_w[2]}, 32'd0);
    chk("async_rst_out_valid", {31'b0, outv_w[2]}, 32'd0);
    chk("async_rst_ovf", {31'b0, ovf_w[2]}, 32'd0);
    cyc();
    rst = 1'b0;
    cyc();
    run_burst(2, 0, 1'b1, 32'h4000_0000, 32'h0000_0004, 1'b0, 1'b0, r_acc, r_ovf);
    chk("post_rst_acc", r_acc, 32'd4);
    chk("post_rst_ovf", {31'b0, r_ovf}, 32'd0);

    for (int i = 0; i < 12; i++) begin
      run_burst(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'b0, 32'd0, 32'd0,
                1'($urandom_range(0, 1)), 1'b0, r_acc, r_ovf);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mac_accumulator.md
# mac_accumulator

Sequential multiply-accumulate stage wrapped around the 32-bit array multiplier. It accepts a burst of exactly `TERMS` operand pairs over a valid/ready handshake and feeds each pair to a `multiplier` instance (`N = 32`). It sums the upper 32 bits of each product into a 32-bit accumulator and presents the final sum with a one-cycle `out_valid` strobe. It is the control and storage stage that drives the combinational multiplier in series and dot-product computations.

## Interface
- `TERMS`, default 8: products per accumulation; legal range 1..255.
- `clk  input  1`: single clock, rising edge.
- `rst  input  1`: asynchronous, active-high reset.
- `start  input  1`: begin a new accumulation. Sampled only in IDLE.
- `x  input  32`: operand A, unsigned.
- `y  input  32`: operand B, unsigned.
- `in_valid  input  1`: `x`/`y` hold a valid pair.
- `in_ready  output  1`: the block accepts a pair this cycle.
- `acc_out  output  32`: accumulated sum.
- `out_valid  output  1`: one-cycle strobe; `acc_out` is final.
- `ovf  output  1`: sticky flag; a carry out of bit 31 occurred during the current accumulation.
- `busy  output  1`: high in every state except IDLE.

## Operation
- Product term = floor(x*y / 2^32), i.e. bits [63:32] of the unsigned 64-bit product. It is taken from the `multiplier` instance output.
- FSM states: IDLE, ACC, DONE.
  - IDLE: `in_ready`=0. If `start`=1 at a clock edge, clear `acc_out`, `ovf`, the accepted counter and the added counter, then go to ACC.
  - ACC: `in_ready` = (accepted < TERMS), combinational from registered state.
  - A pair is accepted at an edge where `in_valid && in_ready`. At that edge the operands are registered into `x_r`/`y_r`, valid bit `v1` is set, and the accepted counter increments.
  - Pipeline stage 2: `prod_r` <= mult(`x_r`,`y_r`)[63:32]; `v2` <= `v1`.
  - Pipeline stage 3: if `v2`, then `acc_out` <= `acc_out` + `prod_r`, the added counter increments, and `ovf` |= carry.
  - When the add that brings the added counter to TERMS occurs, go to DONE on that same edge.
  - DONE: `out_valid`=1 for exactly one cycle, then go to IDLE.
- `acc_out` holds its value in IDLE until the next accepted `start`.
- `start` is ignored in ACC and DONE.
- Pairs presented while `in_ready`=0 are ignored and not counted.
- Gaps in `in_valid` are allowed. Bubbles travel through the pipeline with the valid bits clear.
- Counters are 8 bits wide and never wrap, since TERMS ≤ 255.

## Timing
- Reset values: `acc_out`=0, `out_valid`=0, `ovf`=0, `busy`=0, `in_ready`=0, state=IDLE, `v1`=`v2`=0.
- Reset applies asynchronously at any point, including mid-accumulation. Partial sums and in-flight pairs are discarded.
- Latency: a pair accepted at edge k is added at edge k+2.
- If the last pair is accepted at edge k, `out_valid` is high in the cycle following edge k+2.
- Back-to-back pairs: with `start` at edge 0 and pairs accepted at edges 1..TERMS, `out_valid` is high after edge TERMS+2.
- `in_ready` falls in the cycle after the TERMS-th acceptance.
- `busy` rises the cycle after `start` is accepted and falls when DONE exits.
- The earliest new `start` accepted is at the edge that leaves DONE plus one, i.e. while in IDLE.

## Configuration
- `MAC_SATURATE_EN` defined: on a carry out of bit 31, `acc_out` clamps to 0xFFFFFFFF and stays there for the rest of the accumulation. `ovf` is set.
- Not defined: the sum wraps modulo 2^32. `ovf` is still set sticky.

## Test plan
- TERMS=2; start; pairs (0x80000000, 0x80000000) twice back-to-back -> one-cycle `out_valid` after edge 4, `acc_out`=0x80000000, `ovf`=0.
- TERMS=4; four pairs (0x80000000, 0x80000000) -> `ovf`=1. `acc_out`=0xFFFFFFFF with `MAC_SATURATE_EN`; `acc_out`=0x00000000 without it.
- TERMS=8; pairs (0xFFFFFFFF, 0x00000002) with `in_valid` toggled every other cycle -> `acc_out`=8, exactly 8 acceptances, `ovf`=0.
- TERMS=3; hold `in_valid`=1 for 6 cycles -> `in_ready` low after the 3rd acceptance, `acc_out` sums only 3 products; `start` pulses while `busy`=1 have no effect.
- TERMS=4; assert `rst` after 2 acceptances -> all outputs return to reset values immediately. A new start with four pairs (0x40000000, 0x00000004) then gives `acc_out`=4.
- Pairs with x=0 -> `acc_out`=0, `ovf`=0, `out_valid` pulse of exactly one cycle.
